// File: rtl/pong_pkg.sv
// Shared types and default geometry for the line capture path.
package pong_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {IDLE, FETCH, SEND} drain_state_t;
    typedef enum logic {EMPTY, FULL} bank_state_t;

endpackage

// File: rtl/line_bank.sv
// One line of pixel storage: single write port, registered read port.
module line_bank
    import pong_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  pixel_t        wr_data,
    input  logic          re,
    input  logic [AW-1:0] rd_addr,
    output pixel_t        rd_data
);

    pixel_t mem [DEPTH];
    pixel_t rd_data_q;

    // Read data only changes on re, so it doubles as the hold register for a stalled beat.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/line_capture.sv
// Captures active video lines into two ping-pong banks and drains each
// completed line as a valid/ready burst.
module line_capture #(
    parameter int CORDW = 10,
    parameter int H_RES = pong_pkg::H_RES,
    parameter int V_RES = pong_pkg::V_RES
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic [CORDW-1:0] sdl_sx,
    input  logic [CORDW-1:0] sdl_sy,
    input  logic             sdl_de,
    input  logic [7:0]       sdl_r,
    input  logic [7:0]       sdl_g,
    input  logic [7:0]       sdl_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [23:0]      out_data,
    output logic             out_sof,
    output logic             out_eol,
    output logic [CORDW-1:0] out_line,
    output logic             overflow,
    output logic [7:0]       drop_cnt
);
    import pong_pkg::*;

    localparam int               AW     = $clog2(H_RES);
    localparam logic [CORDW-1:0] X_LAST = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] Y_LIM  = CORDW'(V_RES);

    drain_state_t     state_q, state_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    bank_state_t      bank_st_q [2];
    bank_state_t      bank_st_d [2];
    logic [CORDW-1:0] tag_q [2];
    logic [CORDW-1:0] tag_d [2];
    logic             armed_q, armed_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [CORDW-1:0] x_q, x_d;
    logic [CORDW-1:0] line_q, line_d;

    logic             we, re, drain_done, line_start, wr_free;
    logic [AW-1:0]    rd_addr;
    pixel_t           wr_pix, rd_pix0, rd_pix1, rd_pix;

    assign wr_pix = '{r: sdl_r, g: sdl_g, b: sdl_b};

    always_comb begin
        state_d    = state_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        bank_st_d  = bank_st_q;
        tag_d      = tag_q;
        armed_d    = armed_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        x_d        = x_q;
        line_d     = line_q;
        re         = 1'b0;
        rd_addr    = '0;
        drain_done = 1'b0;
        we         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bank_st_q[rd_bank_q] == FULL) begin
                    state_d = FETCH;
                    line_d  = tag_q[rd_bank_q];
                end
            end
            FETCH: begin
                re      = 1'b1;
                x_d     = '0;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    if (x_q == X_LAST) begin
                        drain_done           = 1'b1;
                        bank_st_d[rd_bank_q] = EMPTY;
                        rd_bank_d            = ~rd_bank_q;
                        state_d              = IDLE;
                    end else begin
                        x_d     = x_q + CORDW'(1);
                        re      = 1'b1;
                        rd_addr = x_d[AW-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A bank freed by the drain this cycle is already usable for the next line.
        line_start = sdl_de && (sdl_sx == '0) && (sdl_sy < Y_LIM);
        wr_free    = (bank_st_q[wr_bank_q] == EMPTY) ||
                     (drain_done && (rd_bank_q == wr_bank_q));

        if (line_start) begin
            if (wr_free) begin
                armed_d = 1'b1;
            end else begin
                armed_d    = 1'b0;
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (!sdl_de || (sdl_sx > X_LAST)) begin
            armed_d = 1'b0;
        end

        we = sdl_de && armed_d && (sdl_sx <= X_LAST);
        if (we && (sdl_sx == X_LAST)) begin
            bank_st_d[wr_bank_q] = FULL;
            tag_d[wr_bank_q]     = sdl_sy;
            wr_bank_d            = ~wr_bank_q;
            armed_d              = 1'b0;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q      <= IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            bank_st_q[0] <= EMPTY;
            bank_st_q[1] <= EMPTY;
            armed_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
            x_q          <= '0;
            line_q       <= '0;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            bank_st_q  <= bank_st_d;
            armed_q    <= armed_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            x_q        <= x_d;
            line_q     <= line_d;
        end
    end

    // Tags are only read while their bank is FULL, so they need no reset.
    always_ff @(posedge clk_pix) begin
        tag_q <= tag_d;
    end

    line_bank #(.DEPTH(H_RES)) u_bank0 (
        .clk     (clk_pix),
        .we      (we && !wr_bank_q),
        .wr_addr (sdl_sx[AW-1:0]),
        .wr_data (wr_pix),
        .re      (re && !rd_bank_q),
        .rd_addr (rd_addr),
        .rd_data (rd_pix0)
    );

    line_bank #(.DEPTH(H_RES)) u_bank1 (
        .clk     (clk_pix),
        .we      (we && wr_bank_q),
        .wr_addr (sdl_sx[AW-1:0]),
        .wr_data (wr_pix),
        .re      (re && rd_bank_q),
        .rd_addr (rd_addr),
        .rd_data (rd_pix1)
    );

    assign rd_pix    = rd_bank_q ? rd_pix1 : rd_pix0;
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? rd_pix : '0;
    assign out_sof   = out_valid && (line_q == '0) && (x_q == '0);
    assign out_eol   = out_valid && (x_q == X_LAST);
    assign out_line  = line_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_line_capture.sv
// Scoreboard bench for line_capture using a short 16-pixel line geometry.
module tb_line_capture;

    localparam int H     = 16;
    localparam int VR    = 8;
    localparam int CORDW = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [CORDW-1:0] sx, sy;
    logic             de;
    logic [7:0]       r, g, b;
    logic             out_valid, out_ready;
    logic [23:0]      out_data;
    logic             out_sof, out_eol;
    logic [CORDW-1:0] out_line;
    logic             overflow;
    logic [7:0]       drop_cnt;

    typedef struct {
        logic [CORDW-1:0] line;
        logic [23:0]      data;
        logic             sof;
        logic             eol;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   beats    = 0;
    int   sof_cnt  = 0;
    int   rdy_mode = 0;

    always #5 clk = ~clk;

    line_capture #(.CORDW(CORDW), .H_RES(H), .V_RES(VR)) dut (
        .clk_pix   (clk),
        .rst_pix_n (rst_n),
        .sdl_sx    (sx),
        .sdl_sy    (sy),
        .sdl_de    (de),
        .sdl_r     (r),
        .sdl_g     (g),
        .sdl_b     (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_line  (out_line),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ready pattern: 0 = always ready, 1 = toggling, 2 = stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b0;
            endcase
        end
    end

    logic             stall_prev = 1'b0;
    logic [23:0]      prev_data;
    logic [CORDW-1:0] prev_line;
    logic             prev_eol;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_line", 32'(out_line), 32'(prev_line));
                check("hold_eol", 32'(out_eol), 32'(prev_eol));
            end
            if (out_valid && out_ready) begin
                beats++;
                if (out_sof) sof_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data", 32'(out_data), 32'(e.data));
                    check("line", 32'(out_line), 32'(e.line));
                    check("sof", 32'(out_sof), 32'(e.sof));
                    check("eol", 32'(out_eol), 32'(e.eol));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_line  = out_line;
            prev_eol   = out_eol;
        end
    end

    // Drives one line from x0, de high while x < len, followed by gap blanking cycles.
    task automatic drive_line(input int y, input int x0, input int len, input int gap, input bit push);
        if (push) begin
            for (int x = 0; x < H; x++) begin
                exp_t e;
                e.line = CORDW'(y);
                e.data = {8'(x), 8'(y), 8'hA5};
                e.sof  = (y == 0) && (x == 0);
                e.eol  = (x == H - 1);
                sb.push_back(e);
            end
        end
        for (int x = x0; x < H + gap; x++) begin
            sx = CORDW'(x);
            sy = CORDW'(y);
            de = (x < len) && (x < H);
            r  = 8'(x);
            g  = 8'(y);
            b  = 8'hA5;
            @(posedge clk);
            #1;
        end
        de = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_data"}, 32'(out_data), 32'd0);
        check({tag, "_sof"}, 32'(out_sof), 32'd0);
        check({tag, "_eol"}, 32'(out_eol), 32'd0);
        check({tag, "_line"}, 32'(out_line), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    endtask

    initial begin
        int target;
        rst_n = 1'b0;
        de = 1'b0; sx = '0; sy = '0; r = '0; g = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Ramp frame with the sink always ready.
        sof_cnt = 0;
        for (int y = 0; y < VR; y++) drive_line(y, 0, H, 8, 1'b1);
        wait_drain("ramp_drain");
        check("ramp_sof_cnt", 32'(sof_cnt), 32'd1);
        check("ramp_drop", 32'(drop_cnt), 32'd0);
        check("ramp_ovf", 32'(overflow), 32'd0);

        // Toggling back-pressure with a longer line period.
        rdy_mode = 1;
        for (int y = 0; y < 4; y++) drive_line(y, 0, H, 24, 1'b1);
        wait_drain("bp_drain");
        check("bp_drop", 32'(drop_cnt), 32'd0);
        check("bp_ovf", 32'(overflow), 32'd0);

        // Stall over three lines: the third finds both banks occupied.
        rdy_mode = 2;
        drive_line(0, 0, H, 8, 1'b1);
        drive_line(1, 0, H, 8, 1'b1);
        drive_line(2, 0, H, 8, 1'b0);
        check("stall_ovf", 32'(overflow), 32'd1);
        check("stall_drop", 32'(drop_cnt), 32'd1);
        rdy_mode = 0;
        wait_drain("stall_drain");

        // de falls mid-line: discarded without counting as a drop.
        drive_line(3, 0, 7, 8, 1'b0);
        drive_line(4, 0, H, 8, 1'b1);
        wait_drain("partial_drain");
        check("partial_drop", 32'(drop_cnt), 32'd1);
        check("partial_ovf", 32'(overflow), 32'd1);

        // Reset in the middle of a burst.
        drive_line(5, 0, H, 0, 1'b1);
        target = beats + 6;
        for (int i = 0; i < 200 && beats < target; i++) @(negedge clk);
        check("burst_started", 32'(beats >= target), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_line(2, 5, H, 8, 1'b0);
        drive_line(3, 0, H, 8, 1'b1);
        wait_drain("after_reset_drain");
        check("after_reset_drop", 32'(drop_cnt), 32'd0);

        // Long stall saturates the drop counter.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) drive_line(i % VR, 0, H, 8, i < 2);
        check("sat_drop", 32'(drop_cnt), 32'd255);
        check("sat_ovf", 32'(overflow), 32'd1);
        rdy_mode = 0;
        wait_drain("sat_drain");
        check("sat_ovf_after", 32'(overflow), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_capture.md
# line_capture

Downstream consumer of the game's pixel stream. Captures each active line (`sdl_sx`, `sdl_sy`, `sdl_de`, 8-bit RGB) into one of two ping-pong line banks. It then drains each completed line as a valid/ready burst toward a frame writer or sim host. This decouples the fixed-rate video timing from a back-pressured sink.

## Interface
- `CORDW`, 10, coordinate width; must match the upstream pixel stream.
- `H_RES`, 640, active pixels per line; bank depth.
- `V_RES`, 480, active lines per frame.
- `clk_pix` in 1: pixel clock; the only clock.
- `rst_pix_n` in 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- `sdl_sx` in CORDW: horizontal position of the incoming pixel.
- `sdl_sy` in CORDW: vertical position of the incoming pixel.
- `sdl_de` in 1: pixel valid; low in blanking.
- `sdl_r` / `sdl_g` / `sdl_b` in 8 each: pixel colour.
- `out_valid` out 1: output pixel valid.
- `out_ready` in 1: sink accepts the pixel.
- `out_data` out 24: {r,g,b} of the current output pixel.
- `out_sof` out 1: first pixel of line 0.
- `out_eol` out 1: last pixel (x = H_RES-1) of a line.
- `out_line` out CORDW: line number of the current burst.
- `overflow` out 1: sticky; set when a line is dropped; cleared only by reset.
- `drop_cnt` out 8: dropped-line count; saturates at 255.

## Operation
- **Capture**
  - A line arms only on `sdl_de` with `sdl_sx`==0.
  - Each `de` cycle writes the pixel at address `sdl_sx` into the current write bank.
  - A line completes on the `de` cycle with `sdl_sx`==H_RES-1. At completion the bank is marked FULL with tag `sdl_sy`, and the write bank toggles.
  - If `de` falls before x = H_RES-1, the partial line is discarded and the bank stays EMPTY. This is not counted as a drop.
  - If the next write bank is still FULL or draining at line start, the line is dropped: `overflow`<=1 and `drop_cnt`++ (saturating). No write occurs and the bank does not toggle.
- **Drain FSM**
  - IDLE: leave to FETCH when the read bank is FULL.
  - FETCH: one-cycle synchronous read of address 0; go to SEND.
  - SEND: present pixel x. On `out_valid && out_ready`, advance x and read x+1.
  - After the beat with x = H_RES-1 is accepted: mark the bank EMPTY, toggle the read bank, return to IDLE.
  - A one-entry skid register sustains 1 pixel/cycle while `out_ready` stays high.
- `out_data`, `out_sof`, `out_eol` and `out_line` are stable while `out_valid && !out_ready`. `out_valid` never drops without acceptance.
- `out_sof` = (`out_line`==0 && x==0). `out_eol` = (x==H_RES-1).
- Address counters are CORDW bits wide, with no wrap past H_RES-1. The bank-select bits are 1 bit each. `drop_cnt` is 8 bits, saturating.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_sof`=0, `out_eol`=0, `out_line`=0, `overflow`=0, `drop_cnt`=0. Both banks EMPTY; write bank = read bank = 0; FSM in IDLE.
- Latency: first `out_valid` 2 cycles after the completing write (mark FULL, then FETCH).
- Throughput: with `out_ready` held high, a line drains in H_RES+2 cycles. This is below the 800-cycle line period, so no drops occur.
- Simultaneous completion of line N and end of drain of the other bank: the freed bank is usable for line N+1 in the same cycle. The EMPTY update takes priority over the line-start check.
- Reset asserted mid-line or mid-burst: everything clears immediately. After release, capture resumes at the next `sx`==0 `de` pixel.

## Structure
- `pong_pkg` holds:
  - `H_RES` and `V_RES` localparams;
  - `pixel_t` packed struct {r,g,b} (8 bits each);
  - the `drain_state_t` enum {IDLE, FETCH, SEND};
  - the `bank_state_t` enum {EMPTY, FULL}.
- Sub-module `line_bank`: an H_RES×24 simple dual-port RAM with one write port and one synchronous read port, instantiated twice.

## Test plan
- Ramp frame: pixel = {x[7:0], y[7:0], 8'hA5}, `out_ready`=1 → every line bursts in order with exact data; `out_sof` once per frame; `out_eol` at x=639; no drops.
- Back-pressure: `out_ready` toggling 50% → data intact and stable while stalled; line 1 is drained before line 3 captures; no drops.
- `out_ready`=0 for 3 line periods → lines 0 and 1 held, line 2 dropped; `overflow`=1, `drop_cnt`=1; release → lines 0 and 1 are output correctly.
- `de` drop at x=300 → line discarded; no burst, `drop_cnt` unchanged; the next full line captures normally.
- Reset asserted at x=200 of a burst → all outputs zero next edge; after release the first burst begins at the next complete line.
- Sustained stall for 300 lines → `drop_cnt` saturates at 255; `overflow` stays 1.
